boot_loader: RTL

Boot sequencer between a host byte stream and the instruction ROM write port of `top_core`. While loading, it holds the core in reset, assembles little-endian words from the stream and writes them to consecutive ROM words from address 0. When loading completes it releases the core. A bench can then load a program over a byte link instead of using `$readmemh`.

---
 rtl/boot_loader_if.sv | 26 ++
 rtl/boot_loader.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/boot_loader_if.sv
// Host byte stream, ROM write port and core-control bundle for boot_loader.
// master = host/bench side, slave = loader side.
interface boot_loader_if #(
  parameter int XLEN   = 32,
  parameter int AWIDTH = 12
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic [AWIDTH-1:0] mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic              mem_we;
  logic              core_rst_n;
  logic              done;
  logic              error;

  modport master (
    output rx_valid, rx_data,
    input  rx_ready, mem_addr, mem_wdata, mem_we, core_rst_n, done, error
  );

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, mem_addr, mem_wdata, mem_we, core_rst_n, done, error
  );
endinterface

// File: rtl/boot_loader.sv
// Boot sequencer: streams little-endian words from a byte link into the instruction ROM,
// then releases the core. Define BOOT_CHECKSUM_EN to require a trailing mod-256 checksum byte.
module boot_loader #(
  parameter int XLEN   = 32,
  parameter int AWIDTH = 12
) (
  input  logic           clk,
  input  logic           rst_n,
  boot_loader_if.slave   bus
);
  localparam int          IDX_W     = AWIDTH - 2;
  localparam logic [31:0] MAX_WORDS = 32'd1 << IDX_W;

  typedef enum logic [2:0] {
    S_LEN,
    S_DATA,
    S_WRITE,
`ifdef BOOT_CHECKSUM_EN
    S_CSUM,
`endif
    S_RUN,
    S_ERROR
  } state_t;

  state_t            state_reg;
  logic [31:0]       count_reg;
  logic [XLEN-1:0]   shift_reg;
  logic [1:0]        byte_cnt_reg;
  logic [IDX_W-1:0]  word_idx_reg;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]        csum_reg;
`endif

  logic              accept;
  logic [31:0]       len_next;
  logic [XLEN-1:0]   word_next;
  logic              last_word;

  // Bytes shift in from the top so byte k ends up in bits [8k+7:8k] after four accepts.
  assign accept    = bus.rx_valid && bus.rx_ready;
  assign len_next  = {bus.rx_data, count_reg[31:8]};
  assign word_next = {bus.rx_data, shift_reg[XLEN-1:8]};
  assign last_word = (32'(word_idx_reg) + 32'd1) == count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= S_LEN;
      count_reg      <= '0;
      shift_reg      <= '0;
      byte_cnt_reg   <= '0;
      word_idx_reg   <= '0;
`ifdef BOOT_CHECKSUM_EN
      csum_reg       <= '0;
`endif
      bus.rx_ready   <= 1'b1;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
      bus.mem_we     <= 1'b0;
      bus.core_rst_n <= 1'b0;
      bus.done       <= 1'b0;
      bus.error      <= 1'b0;
    end else begin
      bus.mem_we <= 1'b0;
      case (state_reg)
        S_LEN: begin
          if (accept) begin
            count_reg    <= len_next;
            byte_cnt_reg <= byte_cnt_reg + 2'd1;
            if (byte_cnt_reg == 2'd3) begin
              if (len_next > MAX_WORDS) begin
                state_reg    <= S_ERROR;
                bus.rx_ready <= 1'b0;
                bus.error    <= 1'b1;
              end else if (len_next == 32'd0) begin
`ifdef BOOT_CHECKSUM_EN
                state_reg      <= S_CSUM;
`else
                state_reg      <= S_RUN;
                bus.rx_ready   <= 1'b0;
                bus.core_rst_n <= 1'b1;
                bus.done       <= 1'b1;
`endif
              end else begin
                state_reg <= S_DATA;
              end
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            shift_reg    <= word_next;
            byte_cnt_reg <= byte_cnt_reg + 2'd1;
`ifdef BOOT_CHECKSUM_EN
            csum_reg     <= csum_reg + bus.rx_data;
`endif
            if (byte_cnt_reg == 2'd3) begin
              state_reg     <= S_WRITE;
              bus.rx_ready  <= 1'b0;
              bus.mem_we    <= 1'b1;
              bus.mem_addr  <= {word_idx_reg, 2'b00};
              bus.mem_wdata <= word_next;
            end
          end
        end
        S_WRITE: begin
          word_idx_reg <= word_idx_reg + 1'b1;
          if (last_word) begin
`ifdef BOOT_CHECKSUM_EN
            state_reg      <= S_CSUM;
            bus.rx_ready   <= 1'b1;
`else
            state_reg      <= S_RUN;
            bus.core_rst_n <= 1'b1;
            bus.done       <= 1'b1;
`endif
          end else begin
            state_reg    <= S_DATA;
            bus.rx_ready <= 1'b1;
          end
        end
`ifdef BOOT_CHECKSUM_EN
        S_CSUM: begin
          if (accept) begin
            bus.rx_ready <= 1'b0;
            if (bus.rx_data == csum_reg) begin
              state_reg      <= S_RUN;
              bus.core_rst_n <= 1'b1;
              bus.done       <= 1'b1;
            end else begin
              state_reg <= S_ERROR;
              bus.error <= 1'b1;
            end
          end
        end
`endif
        S_RUN, S_ERROR: begin
          bus.rx_ready <= 1'b0;
        end
        default: begin
          state_reg      <= S_ERROR;
          bus.rx_ready   <= 1'b0;
          bus.core_rst_n <= 1'b0;
          bus.error      <= 1'b1;
        end
      endcase
    end
  end
endmodule
